// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: reads src+i, writes dst+i, two cycles per byte.
// Shares a single-port memory with combinational read data.
module mem_copy_engine #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] count
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] src_reg, src_next;
  logic [AW-1:0] dst_reg, dst_next;
  logic [AW-1:0] len_reg, len_next;
  logic [AW-1:0] count_reg, count_next;
  logic [DW-1:0] byte_reg, byte_next;
  logic [AW:0]   count_inc;

  // One extra bit so the last-byte compare cannot overflow.
  assign count_inc = {1'b0, count_reg} + {{AW{1'b0}}, 1'b1};
  assign count     = count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      byte_reg  <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      len_reg   <= len_next;
      count_reg <= count_next;
      byte_reg  <= byte_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    len_next   = len_reg;
    count_next = count_reg;
    byte_next  = byte_reg;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          count_next = '0;
          if (len != '0) begin
            src_next   = src_addr;
            dst_next   = dst_addr;
            len_next   = len;
            state_next = RD;
          end else begin
            state_next = FIN;
          end
        end
      end
      RD: begin
        busy       = 1'b1;
        mem_addr   = src_reg + count_reg;
        mem_rd_en  = 1'b1;
        byte_next  = mem_rdata;
        state_next = WR;
      end
      WR: begin
        busy       = 1'b1;
        mem_addr   = dst_reg + count_reg;
        mem_wdata  = byte_reg;
        mem_wr_en  = 1'b1;
        count_next = count_inc[AW-1:0];
        state_next = (count_inc < {1'b0, len_reg}) ? RD : FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: directed scenarios plus random copies
// compared against a sequential array-copy reference model.
module tb_mem_copy_engine;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr, len;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_en, mem_wr_en, busy, done;
  logic [AW-1:0] count;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  int total = 0;
  int bad   = 0;

  mem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Randomise the memory and take a snapshot as the model's starting point.
  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      exp_mem[i] = mem[i];
    end
  endtask

  // Reference: plain ascending byte-by-byte copy with 8-bit wrapping addresses.
  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) exp_mem[8'(d + i)] = exp_mem[8'(s + i)];
  endtask

  function automatic int mem_diffs(output int first_idx);
    int n = 0;
    first_idx = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== exp_mem[i]) begin
        if (first_idx < 0) first_idx = i;
        n++;
      end
    return n;
  endfunction

  // Launch a copy and measure it; lat counts cycles from the start cycle to the done cycle.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                          input int ign_at, output int lat, output int busy_c,
                          output int rd_c, output int wr_c, output int done_c);
    lat = 0; busy_c = 0; rd_c = 0; wr_c = 0; done_c = 0;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      busy_c += int'(busy);
      rd_c   += int'(mem_rd_en);
      wr_c   += int'(mem_wr_en);
      if (done) begin
        done_c++;
        if (lat == 0) lat = k;
      end
      if (k == 1) begin
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom);
      end
      if (ign_at != 0 && k == ign_at) start = 1'b1;
      if (ign_at != 0 && k == ign_at + 1) start = 1'b0;
      if (lat != 0 && k == lat + 1) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    fill_mem();
    @(negedge clk); @(negedge clk);
    total++;
    if ({busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h count=%0d, want all zero",
               busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc, rc, wc, dc, fi;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    model_copy(8'h10, 8'h80, 4);
    run_copy(8'h10, 8'h80, 8'd4, 0, lat, bc, rc, wc, dc);
    total++;
    if (lat !== 9 || bc !== 8 || dc !== 1 || rc !== 4 || wc !== 4) begin
      bad++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d done=%0d rd=%0d wr=%0d, want 9 8 1 4 4", lat, bc, dc, rc, wc);
    end
    total++;
    if ({mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]} !== 32'hA1B2C3D4) begin
      bad++;
      $display("FAIL basic_data: got %h%h%h%h want a1b2c3d4", mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]);
    end
    total++;
    if (mem_diffs(fi) != 0) begin
      bad++;
      $display("FAIL basic_mem: got mem[%0h]=%h want %h", fi, mem[fi], exp_mem[fi]);
    end
    total++;
    if (count !== 8'd4 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
      bad++;
      $display("FAIL basic_idle: got count=%0d addr=%h wdata=%h want 4 00 00", count, mem_addr, mem_wdata);
    end
    $display("basic: src=10 dst=80 len=4 lat=%0d count=%0d", lat, count);
  endtask

  task automatic test_len0();
    int lat, bc, rc, wc, dc, fi;
    run_copy(8'h10, 8'h80, 8'd0, 0, lat, bc, rc, wc, dc);
    total++;
    if (lat !== 1 || bc !== 0 || rc !== 0 || wc !== 0 || dc !== 1 || count !== 8'd0) begin
      bad++;
      $display("FAIL len0: got lat=%0d busy=%0d rd=%0d wr=%0d done=%0d count=%0d, want 1 0 0 0 1 0",
               lat, bc, rc, wc, dc, count);
    end
    total++;
    if (mem_diffs(fi) != 0) begin
      bad++;
      $display("FAIL len0_mem: got mem[%0h]=%h want %h", fi, mem[fi], exp_mem[fi]);
    end
    $display("len0: lat=%0d count=%0d", lat, count);
  endtask

  task automatic test_wrap();
    int lat, bc, rc, wc, dc;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    run_copy(8'hFE, 8'h01, 8'd3, 0, lat, bc, rc, wc, dc);
    total++;
    if ({mem[8'h01], mem[8'h02], mem[8'h03]} !== 24'h112233 || lat !== 7) begin
      bad++;
      $display("FAIL wrap: got %h%h%h lat=%0d want 112233 lat=7", mem[8'h01], mem[8'h02], mem[8'h03], lat);
    end
    $display("wrap: src=fe dst=01 len=3 lat=%0d", lat);
  endtask

  task automatic test_overlap();
    int lat, bc, rc, wc, dc;
    mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h03;
    run_copy(8'h20, 8'h21, 8'd2, 0, lat, bc, rc, wc, dc);
    total++;
    if (mem[8'h21] !== 8'h01 || mem[8'h22] !== 8'h01) begin
      bad++;
      $display("FAIL overlap: got 21=%h 22=%h want 01 01", mem[8'h21], mem[8'h22]);
    end
    $display("overlap: src=20 dst=21 len=2 lat=%0d", lat);
  endtask

  task automatic test_start_ignored();
    int lat, bc, rc, wc, dc, fi, extra;
    fill_mem();
    model_copy(8'h30, 8'hA0, 10);
    run_copy(8'h30, 8'hA0, 8'd10, 5, lat, bc, rc, wc, dc);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      extra += int'(busy) + int'(done);
    end
    total++;
    if (lat !== 21 || dc !== 1 || count !== 8'd10 || extra !== 0) begin
      bad++;
      $display("FAIL start_ignored: got lat=%0d done=%0d count=%0d extra=%0d want 21 1 10 0", lat, dc, count, extra);
    end
    total++;
    if (mem_diffs(fi) != 0) begin
      bad++;
      $display("FAIL start_ignored_mem: got mem[%0h]=%h want %h", fi, mem[fi], exp_mem[fi]);
    end
    $display("start_ignored: len=10 lat=%0d count=%0d", lat, count);
  endtask

  task automatic test_reset_midcopy();
    int lat, bc, rc, wc, dc, fi;
    fill_mem();
    model_copy(8'h40, 8'h90, 2);
    src_addr = 8'h40; dst_addr = 8'h90; len = 8'd8; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (mem_wr_en !== 1'b1 || count !== 8'd2) begin
      bad++;
      $display("FAIL midcopy_phase: got wr=%b count=%0d want 1 2", mem_wr_en, count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, count} !== '0) begin
      bad++;
      $display("FAIL midcopy_async: got busy=%b rd=%b wr=%b addr=%h wdata=%h count=%0d want all zero",
               busy, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, count);
    end
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (mem_diffs(fi) != 0) begin
      bad++;
      $display("FAIL midcopy_mem: got mem[%0h]=%h want %h", fi, mem[fi], exp_mem[fi]);
    end
    model_copy(8'h50, 8'hC0, 5);
    run_copy(8'h50, 8'hC0, 8'd5, 0, lat, bc, rc, wc, dc);
    total++;
    if (lat !== 11 || count !== 8'd5 || mem_diffs(fi) != 0) begin
      bad++;
      $display("FAIL after_reset_copy: got lat=%0d count=%0d want 11 5 (mem diff at %0d)", lat, count, fi);
    end
    $display("reset_midcopy: post-reset copy lat=%0d count=%0d", lat, count);
  endtask

  task automatic test_random();
    int lat, bc, rc, wc, dc, fi, n;
    logic [7:0] s, d;
    fill_mem();
    for (int t = 0; t < 10; t++) begin
      s = 8'($urandom); d = 8'($urandom); n = $urandom_range(1, 24);
      if (t == 9) n = 255;
      model_copy(s, d, n);
      run_copy(s, d, 8'(n), 0, lat, bc, rc, wc, dc);
      total++;
      if (lat !== 2 * n + 1 || bc !== 2 * n || dc !== 1 || count !== 8'(n) || mem_diffs(fi) != 0) begin
        bad++;
        $display("FAIL random_%0d: got lat=%0d busy=%0d done=%0d count=%0d memdiff_at=%0d want lat=%0d busy=%0d done=1 count=%0d",
                 t, lat, bc, dc, count, fi, 2 * n + 1, 2 * n, n);
      end
      $display("random %0d: src=%h dst=%h len=%0d lat=%0d", t, s, d, n, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_overlap();
    test_start_ignored();
    test_reset_midcopy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL expose parameter: AW, 8, address width (memory depth 2^AW bytes).
REQ-002 The block SHALL expose parameter: DW, 8, data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports clk and reset.
REQ-004 clk  input  1  rising-edge clock, shared with the data memory.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a copy; sampled only in IDLE.
REQ-007 src_addr  input  AW  first source byte address.
REQ-008 dst_addr  input  AW  first destination byte address.
REQ-009 len  input  AW  byte count, 0..255.
REQ-010 mem_rdata  input  DW  combinational read data from the data memory.
REQ-011 mem_addr  output  AW  data-memory address.
REQ-012 mem_wdata  output  DW  data-memory write data.
REQ-013 mem_rd_en  output  1  data-memory read enable.
REQ-014 mem_wr_en  output  1  data-memory write enable.
REQ-015 busy  output  1  high while a copy is in progress.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 count  output  AW  bytes written so far in the current or last copy.

Function
REQ-018 States SHALL be IDLE, RD, WR, FIN.
REQ-019 In IDLE with start=1 and len!=0: latch src_addr, dst_addr and len; clear count; go to RD.
REQ-020 In IDLE with start=1 and len=0: clear count, go to FIN, perform no memory access.
REQ-021 RD: mem_addr=src+count, mem_rd_en=1, mem_wr_en=0; mem_rdata captured into an internal byte register at the clock edge; next state WR.
REQ-022 WR: mem_addr=dst+count, mem_wdata=captured byte, mem_wr_en=1, mem_rd_en=0; count increments at the clock edge; next state RD if count+1<len, else FIN.
REQ-023 FIN: done=1 for exactly one cycle, busy=0; next state IDLE.
REQ-024 Each byte SHALL take exactly 2 cycles; a copy of N>0 bytes SHALL show start-to-done latency 2N+1 cycles (start sampled on edge 0, done high in the cycle after edge 2N).
REQ-025 Address sums SHALL wrap modulo 2^AW (e.g. src 0xFF + 1 = 0x00).
REQ-026 Bytes SHALL be copied in ascending order; overlapping regions SHALL give the result of that sequential order, with no special handling.
REQ-027 busy SHALL be 1 in RD and WR only.
REQ-028 start asserted in RD, WR or FIN SHALL be ignored, with no queuing; start in IDLE on the cycle after FIN SHALL be accepted.
REQ-029 Outside RD/WR: mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
REQ-030 count SHALL hold its final value in IDLE until the next accepted start.
REQ-031 Inputs src_addr, dst_addr and len SHALL be ignored after acceptance.

Reset
REQ-032 reset=1 SHALL force IDLE immediately, without waiting for a clock edge.
REQ-033 reset=1 SHALL drive busy=0, done=0, count=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, and clear the byte register.
REQ-034 reset mid-copy SHALL abort the copy: bytes already written remain, and no further write occurs.
REQ-035 After reset deasserts, the block SHALL accept start on the first subsequent edge.

Verification
REQ-036 Memory 0x10..0x13={A1,B2,C3,D4}; start, src=0x10, dst=0x80, len=4 -> 0x80..0x83={A1,B2,C3,D4}; done high 9 cycles after start; count=4; busy high 8 cycles.
REQ-037 len=0, src=0x10, dst=0x80 -> no mem_rd_en or mem_wr_en pulse; done 1 cycle after start; count=0; memory unchanged.
REQ-038 src=0xFE, dst=0x01, len=3, memory 0xFE,0xFF,0x00 = {11,22,33} -> 0x01..0x03 = {11,22,33}; addresses wrap to 0x00.
REQ-039 Overlap: 0x20..0x22={01,02,03}; src=0x20, dst=0x21, len=2 -> 0x21=01, 0x22=01.
REQ-040 Copy len=10; pulse start again at cycle 5 -> second start ignored; exactly one done after 21 cycles; count=10.
REQ-041 Copy len=8; assert reset asynchronously during the 3rd WR -> outputs zero at once, only 2 bytes written; new copy after reset completes normally.
